// File: rtl/pipe_out_arbiter.sv
// Round-robin arbiter sharing one Pipe Out endpoint among NSRC block sources.
// A grant lasts exactly BLOCK_WORDS host reads, followed by at least one idle cycle.
module pipe_out_arbiter #(
    parameter int NSRC        = 4,
    parameter int BLOCK_WORDS = 1024,
    parameter int IDW         = $clog2(NSRC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC-1:0]      src_enable,
    input  logic [NSRC-1:0]      src_ready,
    output logic [NSRC-1:0]      src_read,
    input  logic [NSRC*32-1:0]   src_data,
    input  logic                 pipe_out_read,
    output logic                 pipe_out_ready,
    output logic [31:0]          pipe_out_data,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 block_done,
    output logic                 err_overread,
    output logic [31:0]          blocks_served
);

    localparam int CW = (BLOCK_WORDS > 2) ? $clog2(BLOCK_WORDS) : 1;
    localparam int unsigned N = NSRC;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [NSRC-1:0] req;
    logic [IDW-1:0]  last_ptr;
    logic [CW-1:0]   word_cnt;
    logic            pick_valid;
    logic [IDW-1:0]  pick_id;
    logic            last_read;

    assign req = src_ready & src_enable;

    // Search starts just after the last served source, so the previous winner
    // is considered last.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!pick_valid && req[(32'(last_ptr) + k) % N]) begin
                pick_valid = 1'b1;
                pick_id    = IDW'((32'(last_ptr) + k) % N);
            end
        end
    end

    assign last_read = (state == BURST) && pipe_out_read &&
                       (word_cnt == CW'(BLOCK_WORDS - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_valid) state_nx = BURST;
            BURST:   if (last_read)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        src_read      = '0;
        pipe_out_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_id == IDW'(i)) begin
                src_read[i]   = (state == BURST) && pipe_out_read;
                pipe_out_data = src_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pipe_out_ready <= 1'b0;
            busy           <= 1'b0;
            block_done     <= 1'b0;
            err_overread   <= 1'b0;
            grant_id       <= '0;
            blocks_served  <= '0;
            word_cnt       <= '0;
            last_ptr       <= IDW'(NSRC - 1);
        end else begin
            state          <= state_nx;
            pipe_out_ready <= (state_nx == BURST);
            busy           <= (state_nx == BURST);
            block_done     <= last_read;
            err_overread   <= (state == IDLE) && pipe_out_read;
            if (state == IDLE) begin
                word_cnt <= '0;
                if (pick_valid) grant_id <= pick_id;
            end else if (pipe_out_read) begin
                word_cnt <= word_cnt + CW'(1);
            end
            if (last_read) begin
                last_ptr      <= grant_id;
                blocks_served <= blocks_served + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// Scoreboard bench for pipe_out_arbiter: expected grant ids are queued when
// requests are driven and checked as each block is granted.
module tb_pipe_out_arbiter;

    localparam int NSRC = 4;
    localparam int BW   = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic [NSRC-1:0]   src_enable;
    logic [NSRC-1:0]   src_ready;
    logic [NSRC-1:0]   src_read;
    logic [NSRC*32-1:0] src_data;
    logic              pipe_out_read;
    logic              pipe_out_ready;
    logic [31:0]       pipe_out_data;
    logic [1:0]        grant_id;
    logic              busy;
    logic              block_done;
    logic              err_overread;
    logic [31:0]       blocks_served;

    int n_vec = 0;
    int n_err = 0;
    int exp_served = 0;
    int exp_q[$];

    pipe_out_arbiter #(.NSRC(NSRC), .BLOCK_WORDS(BW), .IDW(2)) dut (
        .clk(clk), .reset(reset), .src_enable(src_enable), .src_ready(src_ready),
        .src_read(src_read), .src_data(src_data), .pipe_out_read(pipe_out_read),
        .pipe_out_ready(pipe_out_ready), .pipe_out_data(pipe_out_data),
        .grant_id(grant_id), .busy(busy), .block_done(block_done),
        .err_overread(err_overread), .blocks_served(blocks_served)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int w);
        for (int i = 0; i < NSRC; i++) src_data[32*i +: 32] = {8'(i + 1), 24'(w)};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pipe_out_read = 1'b0;
        @(negedge clk);
        expect_eq("rst_ready", pipe_out_ready, 0);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_done", block_done, 0);
        expect_eq("rst_overread", err_overread, 0);
        expect_eq("rst_grant", grant_id, 0);
        expect_eq("rst_served", blocks_served, 0);
        expect_eq("rst_read", src_read, 0);
        exp_served = 0;
        reset = 1'b0;
    endtask

    // Waits (bounded) for a grant, checks it against the scoreboard, then
    // issues nreads reads. drop_at clears the granted source's ready mid-burst.
    task automatic run_block(input int nreads, input int drop_at);
        int gid;
        int waited = 0;
        while (pipe_out_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (pipe_out_ready !== 1'b1) begin
            expect_eq("ready_timeout", pipe_out_ready, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            expect_eq("sb_unexpected_grant", grant_id, 32'hFFFF_FFFF);
            return;
        end
        gid = exp_q.pop_front();
        expect_eq("grant_id", grant_id, gid);
        expect_eq("busy", busy, 1);
        for (int w = 0; w < nreads; w++) begin
            if (w == drop_at) src_ready[gid] = 1'b0;
            set_data(w);
            pipe_out_read = 1'b1;
            #1;
            expect_eq("src_read", src_read, 32'(1) << gid);
            expect_eq("data", pipe_out_data, {8'(gid + 1), 24'(w)});
            @(negedge clk);
        end
        pipe_out_read = 1'b0;
        if (nreads == BW) begin
            exp_served++;
            expect_eq("block_done", block_done, 1);
            expect_eq("ready_after_block", pipe_out_ready, 0);
            expect_eq("busy_after_block", busy, 0);
            expect_eq("blocks_served", blocks_served, exp_served);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        src_enable = '0;
        src_ready = '0;
        src_data = '0;
        pipe_out_read = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        do_reset();

        // 1: single requester, latency, then re-grant after mandatory idle
        src_enable = 4'hF;
        src_ready = 4'b0001;
        #1;
        expect_eq("t1_ready_early", pipe_out_ready, 0);
        @(negedge clk);
        expect_eq("t1_latency", pipe_out_ready, 1);
        exp_q.push_back(0);
        run_block(BW, -1);
        exp_q.push_back(0);
        run_block(BW, -1);
        src_ready = '0;

        // 2: all requesting, round-robin 0,1,2,3,0
        do_reset();
        src_ready = 4'hF;
        foreach (exp_q[i]) exp_q.delete(i);
        for (int i = 0; i < 5; i++) exp_q.push_back(i % NSRC);
        for (int i = 0; i < 5; i++) run_block(BW, -1);
        src_ready = '0;

        // 3: granted source drops ready mid-burst; block still completes
        src_ready = 4'b0100;
        exp_q.push_back(2);
        run_block(BW, 10);

        // 4: read in IDLE
        @(negedge clk);
        pipe_out_read = 1'b1;
        #1;
        expect_eq("t4_src_read", src_read, 0);
        @(negedge clk);
        pipe_out_read = 1'b0;
        expect_eq("t4_overread", err_overread, 1);
        expect_eq("t4_busy", busy, 0);
        @(negedge clk);
        expect_eq("t4_overread_clr", err_overread, 0);

        // 5: masked sources alternate 1,3,1,3
        do_reset();
        src_enable = 4'b1010;
        src_ready = 4'hF;
        for (int i = 0; i < 4; i++) exp_q.push_back(i % 2 ? 3 : 1);
        for (int i = 0; i < 4; i++) run_block(BW, -1);

        // 6: reset mid-burst, then source 0 wins first
        exp_q.push_back(1);
        run_block(500, -1);
        src_enable = 4'hF;
        do_reset();
        exp_q.push_back(0);
        run_block(BW, -1);
        src_ready = '0;
        @(negedge clk);
        expect_eq("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
